charge_display: RTL and testbench

Downstream consumer of the call-charging controller's `charge`/`fin` outputs. On each completed charge it captures the 4-bit charge, adds it to a 3-digit BCD running total, and drives the multiplexed 8-digit active-low seven-segment display. The display shows the running total and the last charge. It replaces the idle-banner driver during billing display.

---
 rtl/charge_display_if.sv | 27 ++
 rtl/charge_display.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_charge_display.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/charge_display_if.sv
// Charge/display bus between the charging controller side and charge_display.
interface charge_display_if;
    localparam int unsigned CHG_W   = 4;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned TOTAL_W = 12;
    localparam int unsigned LAST_W  = 8;

    logic               fin;
    logic [CHG_W-1:0]   charge;
    logic               clear;
    logic [SEG_W-1:0]   show;
    logic [SEG_W-1:0]   en;
    logic [TOTAL_W-1:0] total;
    logic [LAST_W-1:0]  last;
    logic               busy;
    logic               ovf;

    modport master (
        output fin, charge, clear,
        input  show, en, total, last, busy, ovf
    );

    modport slave (
        input  fin, charge, clear,
        output show, en, total, last, busy, ovf
    );
endinterface

// File: rtl/charge_display.sv
// charge_display: accumulates completed call charges into a 3-digit BCD total
// and scans total/last charge onto an 8-digit active-low seven-segment display.
// Optional feature macro: CHARGE_DISPLAY_LZB_EN (leading-zero blanking).
module charge_display #(
    parameter int unsigned SCAN_DIV = 10000
) (
    input  logic      clk,
    input  logic      reset,
    charge_display_if.slave bus
);
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned TOTAL_W = 12;
    localparam int unsigned LAST_W  = 8;

`ifdef CHARGE_DISPLAY_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD_U = 2'd1,
        S_ADD_T = 2'd2,
        S_ADD_H = 2'd3
    } state_t;

    // Binary 0..15 to two BCD digits {tens, ones}.
    function automatic logic [LAST_W-1:0] to_bcd2(input logic [DIG_W-1:0] v);
        if (v > 4'd9) begin
            to_bcd2 = {4'd1, 4'(v - 4'd10)};
        end else begin
            to_bcd2 = {4'd0, v};
        end
    endfunction

    // Active-low segment code, dp off; non-decimal codes go dark.
    function automatic logic [SEG_W-1:0] seg7(input logic [DIG_W-1:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic                 fin_d_q;
    logic [DIG_W-1:0]     op_u_q, op_u_d, op_t_q, op_t_d;
    logic [DIG_W-1:0]     sh_u_q, sh_u_d, sh_t_q, sh_t_d, sh_h_q, sh_h_d;
    logic                 carry_q, carry_d;
    logic [TOTAL_W-1:0]   total_q, total_d;
    logic [LAST_W-1:0]    last_q, last_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 pend_q, pend_d;
    logic [DIG_W-1:0]     pend_chg_q, pend_chg_d;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SEG_W-1:0]     show_q, show_d;
    logic [SEG_W-1:0]     en_q, en_d;

    logic                 detect_c;
    logic                 start_c;
    logic                 start_pend_c;
    logic [DIG_W-1:0]     start_val_c;
    logic [LAST_W-1:0]    start_bcd_c;
    logic [DIG_W:0]       sum_u_c, sum_t_c, sum_h_c;
    logic                 sat_c;
    logic [TOTAL_W-1:0]   commit_c;

    assign detect_c    = bus.fin & ~fin_d_q;
    assign start_bcd_c = to_bcd2(start_val_c);

    // Decimal adder stages and the value committed at the end of ADD_H.
    assign sum_u_c  = 5'(sh_u_q) + 5'(op_u_q);
    assign sum_t_c  = 5'(sh_t_q) + 5'(op_t_q) + 5'(carry_q);
    assign sum_h_c  = 5'(sh_h_q) + 5'(carry_q);
    assign sat_c    = (sum_h_c > 5'd9);
    assign commit_c = sat_c ? 12'h999 : {sum_h_c[DIG_W-1:0], sh_t_q, sh_u_q};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a pending charge is preferred over a fresh detect in ADD_H.
    always_comb begin
        state_d      = state_q;
        start_c      = 1'b0;
        start_pend_c = 1'b0;
        start_val_c  = bus.charge;
        case (state_q)
            S_IDLE: begin
                if (detect_c) begin
                    state_d = S_ADD_U;
                    start_c = 1'b1;
                end else if (pend_q) begin
                    state_d      = S_ADD_U;
                    start_c      = 1'b1;
                    start_pend_c = 1'b1;
                    start_val_c  = pend_chg_q;
                end
            end
            S_ADD_U: state_d = S_ADD_T;
            S_ADD_T: state_d = S_ADD_H;
            S_ADD_H: begin
                if (pend_q) begin
                    state_d      = S_ADD_U;
                    start_c      = 1'b1;
                    start_pend_c = 1'b1;
                    start_val_c  = pend_chg_q;
                end else if (detect_c) begin
                    state_d = S_ADD_U;
                    start_c = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.clear) begin
            state_d      = S_IDLE;
            start_c      = 1'b0;
            start_pend_c = 1'b0;
        end
    end

    // Datapath next values: capture, per-digit add, commit, pending slot, clear.
    always_comb begin
        op_u_d     = op_u_q;
        op_t_d     = op_t_q;
        sh_u_d     = sh_u_q;
        sh_t_d     = sh_t_q;
        sh_h_d     = sh_h_q;
        carry_d    = carry_q;
        total_d    = total_q;
        last_d     = last_q;
        ovf_d      = ovf_q;
        pend_d     = pend_q;
        pend_chg_d = pend_chg_q;
        busy_d     = (state_d != S_IDLE);

        case (state_q)
            S_ADD_U: begin
                if (sum_u_c > 5'd9) begin
                    sh_u_d  = 4'(sum_u_c - 5'd10);
                    carry_d = 1'b1;
                end else begin
                    sh_u_d  = sum_u_c[DIG_W-1:0];
                    carry_d = 1'b0;
                end
            end
            S_ADD_T: begin
                if (sum_t_c > 5'd9) begin
                    sh_t_d  = 4'(sum_t_c - 5'd10);
                    carry_d = 1'b1;
                end else begin
                    sh_t_d  = sum_t_c[DIG_W-1:0];
                    carry_d = 1'b0;
                end
            end
            S_ADD_H: begin
                total_d = commit_c;
                ovf_d   = ovf_q | sat_c;
            end
            default: ;
        endcase

        // Busy-time detect fills the one-deep slot; ADD_H starts a fresh detect directly.
        if (detect_c && !pend_q && (state_q == S_ADD_U || state_q == S_ADD_T)) begin
            pend_d     = 1'b1;
            pend_chg_d = bus.charge;
        end

        if (start_c) begin
            last_d  = start_bcd_c;
            op_t_d  = start_bcd_c[7:4];
            op_u_d  = start_bcd_c[3:0];
            carry_d = 1'b0;
            {sh_h_d, sh_t_d, sh_u_d} = (state_q == S_ADD_H) ? commit_c : total_q;
            if (start_pend_c) begin
                pend_d = 1'b0;
            end
        end

        if (bus.clear) begin
            op_u_d     = '0;
            op_t_d     = '0;
            sh_u_d     = '0;
            sh_t_d     = '0;
            sh_h_d     = '0;
            carry_d    = 1'b0;
            total_d    = '0;
            last_d     = '0;
            ovf_d      = 1'b0;
            pend_d     = 1'b0;
            pend_chg_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fin_d_q    <= 1'b0;
            op_u_q     <= '0;
            op_t_q     <= '0;
            sh_u_q     <= '0;
            sh_t_q     <= '0;
            sh_h_q     <= '0;
            carry_q    <= 1'b0;
            total_q    <= '0;
            last_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_chg_q <= '0;
        end else begin
            fin_d_q    <= bus.fin;
            op_u_q     <= op_u_d;
            op_t_q     <= op_t_d;
            sh_u_q     <= sh_u_d;
            sh_t_q     <= sh_t_d;
            sh_h_q     <= sh_h_d;
            carry_q    <= carry_d;
            total_q    <= total_d;
            last_q     <= last_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            pend_chg_q <= pend_chg_d;
        end
    end

    // Scan prescaler, digit selection and segment/enable encoding.
    always_comb begin
        logic [DIG_W-1:0] digit;
        logic             blank;
        logic             off;
        digit = '0;
        blank = 1'b0;
        off   = 1'b0;
        case (idx_q)
            3'd0: digit = total_q[3:0];
            3'd1: begin
                digit = total_q[7:4];
                blank = LZB && (total_q[11:8] == 4'd0) && (total_q[7:4] == 4'd0);
            end
            3'd2: begin
                digit = total_q[11:8];
                blank = LZB && (total_q[11:8] == 4'd0);
            end
            3'd4: digit = last_q[3:0];
            3'd5: begin
                digit = last_q[7:4];
                blank = LZB && (last_q[7:4] == 4'd0);
            end
            default: off = 1'b1;
        endcase
        en_d   = off ? 8'hFF : ~(8'h01 << idx_q);
        show_d = (off || blank) ? 8'hFF : seg7(digit);
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
            idx_d = idx_q;
        end
    end

    // Display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            show_q <= 8'hFF;
            en_q   <= 8'hFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            show_q <= show_d;
            en_q   <= en_d;
        end
    end

    assign bus.show  = show_q;
    assign bus.en    = en_q;
    assign bus.total = total_q;
    assign bus.last  = last_q;
    assign bus.busy  = busy_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_charge_display.sv
// Directed bench for charge_display with a short scan period.
module tb_charge_display;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

`ifdef CHARGE_DISPLAY_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    charge_display_if bus();

    charge_display #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add_charge(input logic [3:0] v);
        bus.fin    = 1'b1;
        bus.charge = v;
        step(1);
        bus.fin = 1'b0;
        step(3);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        step(1);
    endtask

    task automatic sync_scan(output bit found);
        logic [7:0] prev;
        found = 1'b0;
        prev  = bus.en;
        for (int i = 0; i < 64 && !found; i++) begin
            step(1);
            if (bus.en == 8'hFE && prev != 8'hFE) found = 1'b1;
            else prev = bus.en;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL scan_sync: en never entered FE, last en=%h", bus.en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        checks++; if (bus.show !== 8'hFF) begin errors++; $display("FAIL reset_show: got %h want FF", bus.show); end
        checks++; if (bus.en !== 8'hFF) begin errors++; $display("FAIL reset_en: got %h want FF", bus.en); end
        checks++; if (bus.total !== 12'h000) begin errors++; $display("FAIL reset_total: got %h want 000", bus.total); end
        checks++; if (bus.last !== 8'h00) begin errors++; $display("FAIL reset_last: got %h want 00", bus.last); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        reset = 1'b0;
        step(1);
        checks++; if (bus.en !== 8'hFE) begin errors++; $display("FAIL release_en: got %h want FE", bus.en); end
        checks++; if (bus.show !== 8'hC0) begin errors++; $display("FAIL release_show: got %h want C0", bus.show); end
    endtask

    task automatic test_single();
        int busy_cnt;
        bus.fin    = 1'b1;
        bus.charge = 4'd7;
        step(1);
        checks++; if (bus.last !== 8'h07) begin errors++; $display("FAIL single_last: got %h want 07", bus.last); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_n: got %b want 1", bus.busy); end
        step(2);
        checks++; if (bus.total !== 12'h000) begin errors++; $display("FAIL single_total_n2: got %h want 000", bus.total); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_n2: got %b want 1", bus.busy); end
        step(1);
        checks++; if (bus.total !== 12'h007) begin errors++; $display("FAIL single_total_n3: got %h want 007", bus.total); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_n3: got %b want 0", bus.busy); end
        busy_cnt = 0;
        for (int i = 0; i < 46; i++) begin
            step(1);
            if (bus.busy) busy_cnt++;
        end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL single_held_busy: got %0d busy cycles want 0", busy_cnt); end
        checks++; if (bus.total !== 12'h007) begin errors++; $display("FAIL single_held_total: got %h want 007", bus.total); end
        bus.fin = 1'b0;
        step(1);
    endtask

    task automatic test_carry();
        do_clear();
        for (int i = 0; i < 6; i++) add_charge(4'd15);
        add_charge(4'd5);
        checks++; if (bus.total !== 12'h095) begin errors++; $display("FAIL carry_preload: got %h want 095", bus.total); end
        add_charge(4'd15);
        checks++; if (bus.total !== 12'h110) begin errors++; $display("FAIL carry_total: got %h want 110", bus.total); end
        checks++; if (bus.last !== 8'h15) begin errors++; $display("FAIL carry_last: got %h want 15", bus.last); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bh;
        do_clear();
        bus.fin = 1'b1; bus.charge = 4'd9;
        step(1); bh[0] = bus.busy;
        bus.fin = 1'b0;
        step(1); bh[1] = bus.busy;
        bus.fin = 1'b1; bus.charge = 4'd4;
        step(1); bh[2] = bus.busy;
        bus.fin = 1'b0;
        for (int i = 3; i < 8; i++) begin
            step(1);
            bh[i] = bus.busy;
        end
        checks++; if (bh !== 8'b0011_1111) begin errors++; $display("FAIL b2b_busy: got %b want 00111111", bh); end
        checks++; if (bus.total !== 12'h013) begin errors++; $display("FAIL b2b_total: got %h want 013", bus.total); end
        checks++; if (bus.last !== 8'h04) begin errors++; $display("FAIL b2b_last: got %h want 04", bus.last); end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < 66; i++) add_charge(4'd15);
        checks++; if (bus.total !== 12'h990) begin errors++; $display("FAIL sat_pre_total: got %h want 990", bus.total); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL sat_pre_ovf: got %b want 0", bus.ovf); end
        add_charge(4'd15);
        checks++; if (bus.total !== 12'h999) begin errors++; $display("FAIL sat_total: got %h want 999", bus.total); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", bus.ovf); end
        add_charge(4'd3);
        checks++; if (bus.total !== 12'h999) begin errors++; $display("FAIL sat_hold_total: got %h want 999", bus.total); end
        checks++; if (bus.last !== 8'h03) begin errors++; $display("FAIL sat_hold_last: got %h want 03", bus.last); end
        bus.clear = 1'b1; bus.fin = 1'b1; bus.charge = 4'd3;
        step(1);
        bus.clear = 1'b0;
        step(1);
        bus.fin = 1'b0;
        step(3);
        checks++; if (bus.total !== 12'h000) begin errors++; $display("FAIL clr_total: got %h want 000", bus.total); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", bus.ovf); end
        checks++; if (bus.last !== 8'h00) begin errors++; $display("FAIL clr_last: got %h want 00", bus.last); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_scan();
        logic [7:0] exp_en   [8];
        logic [7:0] exp_show [8];
        bit         found;
        int         pos;
        do_clear();
        for (int i = 0; i < 20; i++) add_charge(4'd15);
        add_charge(4'd5);
        checks++; if (bus.total !== 12'h305) begin errors++; $display("FAIL scan_total: got %h want 305", bus.total); end
        exp_en   = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
        exp_show = '{8'h92, 8'hC0, 8'hB0, 8'hFF, 8'h92, (LZB ? 8'hFF : 8'hC0), 8'hFF, 8'hFF};
        sync_scan(found);
        if (found) begin
            for (int k = 0; k < 32; k++) begin
                if (k > 0) step(1);
                pos = k / 4;
                checks++;
                if (bus.en !== exp_en[pos]) begin errors++; $display("FAIL scan_en[%0d]: got %h want %h", k, bus.en, exp_en[pos]); end
                checks++;
                if (bus.show !== exp_show[pos]) begin errors++; $display("FAIL scan_show[%0d]: got %h want %h", k, bus.show, exp_show[pos]); end
            end
        end
    endtask

    task automatic test_lzb();
        bit found;
        do_clear();
        add_charge(4'd5);
        sync_scan(found);
        if (found) begin
            checks++; if (bus.show !== 8'h92) begin errors++; $display("FAIL lzb_units: got %h want 92", bus.show); end
            step(4);
            checks++; if (bus.en !== 8'hFD) begin errors++; $display("FAIL lzb_tens_en: got %h want FD", bus.en); end
            checks++; if (bus.show !== (LZB ? 8'hFF : 8'hC0)) begin errors++; $display("FAIL lzb_tens_show: got %h want %h", bus.show, (LZB ? 8'hFF : 8'hC0)); end
            step(4);
            checks++; if (bus.en !== 8'hFB) begin errors++; $display("FAIL lzb_hund_en: got %h want FB", bus.en); end
            checks++; if (bus.show !== (LZB ? 8'hFF : 8'hC0)) begin errors++; $display("FAIL lzb_hund_show: got %h want %h", bus.show, (LZB ? 8'hFF : 8'hC0)); end
            step(12);
            checks++; if (bus.en !== 8'hDF) begin errors++; $display("FAIL lzb_ltens_en: got %h want DF", bus.en); end
            checks++; if (bus.show !== (LZB ? 8'hFF : 8'hC0)) begin errors++; $display("FAIL lzb_ltens_show: got %h want %h", bus.show, (LZB ? 8'hFF : 8'hC0)); end
        end
    endtask

    task automatic test_reset_mid();
        bus.fin = 1'b1; bus.charge = 4'd9;
        step(1);
        bus.fin = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.total !== 12'h000) begin errors++; $display("FAIL rmid_total: got %h want 000", bus.total); end
        checks++; if (bus.last !== 8'h00) begin errors++; $display("FAIL rmid_last: got %h want 00", bus.last); end
        checks++; if (bus.en !== 8'hFF) begin errors++; $display("FAIL rmid_en: got %h want FF", bus.en); end
        reset = 1'b0;
        step(4);
        checks++; if (bus.total !== 12'h000) begin errors++; $display("FAIL rmid_after_total: got %h want 000", bus.total); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_after_busy: got %b want 0", bus.busy); end
    endtask

    initial begin
        bus.fin    = 1'b0;
        bus.charge = 4'd0;
        bus.clear  = 1'b0;
        test_reset();
        test_single();
        test_carry();
        test_back_to_back();
        test_saturation();
        test_scan();
        test_lzb();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
